truth_table_checker: RTL and testbench

- Hardware counterpart of the exhaustive 4-input stimulus bench used for the lab combinational functions (SOM/POS forms).
- Generates every input vector {A,B,C,D} in order 0000..1111 and drives the DUT's inputs.
- Samples the DUT's F after a settle window and compares it against a parameterised expected truth table.
- Reports pass/fail, mismatch count and the first failing vector, so the check runs on the board with no simulator.

---
 rtl/tt_check_pkg.sv | 14 +
 rtl/tt_settle_timer.sv | 28 ++
 rtl/truth_table_checker.sv | 111 +++++++++++
 tb/tb_truth_table_checker.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/tt_check_pkg.sv
// Shared types and constants for the lab truth-table sweepers.
// Latency/backpressure: not applicable (definitions only).
package tt_check_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int TT_N_IN          = 4;
    localparam int TT_SETTLE_CYCLES = 10;

    // Expected F columns for the lab functions, bit i = F at {A,B,C,D} == i.
    localparam logic [15:0] TT_EXP_SOM = 16'hA5C3;
    localparam logic [15:0] TT_EXP_POS = 16'h3C5A;

endpackage

// File: rtl/tt_settle_timer.sv
// Loadable down-counter with zero flag; load takes effect next edge, holds at zero.
// Latency: one cycle from load to count; backpressure: none, en gates decrement.
module tt_settle_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/truth_table_checker.sv
// Sweeps all 2**N_IN input vectors, samples f_in after SETTLE_CYCLES and scores against EXPECTED.
// Latency: 2**N_IN*SETTLE_CYCLES cycles per sweep; start ignored while busy. Optional TT_CAPTURE_EN adds captured.
module truth_table_checker
    import tt_check_pkg::*;
#(
    parameter int                   N_IN          = TT_N_IN,
    parameter int                   SETTLE_CYCLES = TT_SETTLE_CYCLES,
    parameter logic [(2**N_IN)-1:0] EXPECTED      = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            f_in,
    output logic [N_IN-1:0] vec_out,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   fail_count,
    output logic [N_IN-1:0] first_fail_vec,
    output logic            first_fail_valid
`ifdef TT_CAPTURE_EN
    ,
    output logic [(2**N_IN)-1:0] captured
`endif
);

    localparam int              NV       = 2**N_IN;
    localparam logic [N_IN:0]   FC_MAX   = (N_IN+1)'(NV);
    localparam logic [N_IN-1:0] VEC_LAST = N_IN'(NV-1);
    localparam logic [7:0]      RELOAD   = 8'(SETTLE_CYCLES-1);

    state_t        state;
    logic          armed;
    logic          tmr_zero;
    logic          accept;
    logic          sample;
    logic          mismatch;
    logic [N_IN:0] fc_nxt;

    // armed masks the first edge after reset release so a coincident start is dropped.
    assign accept   = start && armed && (state != RUN);
    assign sample   = (state == RUN) && tmr_zero;
    assign mismatch = (f_in != EXPECTED[vec_out]);
    assign fc_nxt   = (mismatch && fail_count != FC_MAX) ? fail_count + 1'b1 : fail_count;

    tt_settle_timer #(.W(8)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept || sample),
        .load_val (RELOAD),
        .en       (state == RUN),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            armed            <= 1'b0;
            vec_out          <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            fail_count       <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
`ifdef TT_CAPTURE_EN
            captured         <= '0;
`endif
        end else begin
            armed <= 1'b1;
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        state            <= RUN;
                        vec_out          <= '0;
                        fail_count       <= '0;
                        first_fail_vec   <= '0;
                        first_fail_valid <= 1'b0;
                        done             <= 1'b0;
                        pass             <= 1'b0;
                        busy             <= 1'b1;
`ifdef TT_CAPTURE_EN
                        captured         <= '0;
`endif
                    end
                end
                RUN: begin
                    if (sample) begin
                        fail_count <= fc_nxt;
                        vec_out    <= vec_out + 1'b1;
`ifdef TT_CAPTURE_EN
                        captured[vec_out] <= f_in;
`endif
                        if (mismatch && !first_fail_valid) begin
                            first_fail_vec   <= vec_out;
                            first_fail_valid <= 1'b1;
                        end
                        if (vec_out == VEC_LAST) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (fc_nxt == '0);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_checker.sv
// Directed bench: model DUT answers from the expected table with selectable corruption.
module tb_truth_table_checker;
    import tt_check_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        start1 = 1'b0;
    logic [15:0] exp_v = 16'hA5C3;
    int          mode = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    int          cycles;

    logic [3:0] vec0, vec1, ffv0, ffv1;
    logic       f0, f1, busy0, busy1, done0, done1, pass0, pass1, ffok0, ffok1;
    logic [4:0] fc0, fc1;
`ifdef TT_CAPTURE_EN
    logic [15:0] cap0, cap1;
`endif

    always #5 clk = ~clk;

    // mode 0: correct DUT, 1: wrong only at vector 6, 2: every vector inverted.
    assign f0 = exp_v[vec0] ^ ((mode == 2) || (mode == 1 && vec0 == 4'd6));
    assign f1 = exp_v[vec1];

    truth_table_checker #(.N_IN(4), .SETTLE_CYCLES(10), .EXPECTED(TT_EXP_SOM)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .f_in(f0), .vec_out(vec0),
        .busy(busy0), .done(done0), .pass(pass0), .fail_count(fc0),
        .first_fail_vec(ffv0), .first_fail_valid(ffok0)
`ifdef TT_CAPTURE_EN
        , .captured(cap0)
`endif
    );

    truth_table_checker #(.N_IN(4), .SETTLE_CYCLES(1), .EXPECTED(TT_EXP_SOM)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .f_in(f1), .vec_out(vec1),
        .busy(busy1), .done(done1), .pass(pass1), .fail_count(fc1),
        .first_fail_vec(ffv1), .first_fail_valid(ffok1)
`ifdef TT_CAPTURE_EN
        , .captured(cap1)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Pulses start, optionally re-pulses it at cycle restart_at, returns cycles until done.
    task automatic run_sweep(input int restart_at, output int ncyc);
        ncyc = -1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("accept_done_low", done0, 0);
        chk("accept_busy", busy0, 1);
        for (int n = 1; n <= 400; n++) begin
            @(posedge clk);
            #1;
            start = (n == restart_at);
            if (done0) begin
                ncyc = n;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic chk_result(input string tag, input int fc, input int ffv,
                              input int ffok, input int ps);
        chk({tag, "_fail_count"}, fc0, fc);
        chk({tag, "_first_vec"}, ffv0, ffv);
        chk({tag, "_first_valid"}, ffok0, ffok);
        chk({tag, "_pass"}, pass0, ps);
        chk({tag, "_busy"}, busy0, 0);
    endtask

    initial begin
        wait_cycles(3);
        chk("rst_vec", vec0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_pass", pass0, 0);
        chk("rst_fc", fc0, 0);
        chk("rst_ffvalid", ffok0, 0);

        // start held through the release edge must be dropped
        rst_n = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("release_start_ignored", busy0, 0);
        wait_cycles(3);
        chk("release_idle", busy0, 0);

        mode = 0;
        run_sweep(0, cycles);
        chk("good_cycles", cycles, 160);
        chk_result("good", 0, 0, 0, 1);
`ifdef TT_CAPTURE_EN
        chk("good_captured", cap0, 16'hA5C3);
`endif

        mode = 1;
        run_sweep(0, cycles);
        chk("one_cycles", cycles, 160);
        chk_result("one", 1, 6, 1, 0);

        mode = 2;
        run_sweep(0, cycles);
        chk("all_cycles", cycles, 160);
        chk_result("all", 16, 0, 1, 0);

        mode = 1;
        run_sweep(50, cycles);
        chk("restart_cycles", cycles, 160);
        chk_result("restart", 1, 6, 1, 0);
        run_sweep(0, cycles);
        chk("again_cycles", cycles, 160);
        chk_result("again", 1, 6, 1, 0);

        mode = 2;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_cycles(75);
        chk("pre_rst_busy", busy0, 1);
        chk("pre_rst_fc", fc0, 7);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy0, 0);
        chk("mid_rst_vec", vec0, 0);
        chk("mid_rst_fc", fc0, 0);
        chk("mid_rst_ffvalid", ffok0, 0);
        chk("mid_rst_done", done0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_cycles(20);
        chk("post_rst_idle", busy0, 0);
        chk("post_rst_done", done0, 0);
        chk("post_rst_vec", vec0, 0);

        cycles = -1;
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk);
            #1;
            if (n == 3) chk("fast_vec_at3", vec1, 3);
            if (done1) begin
                cycles = n;
                break;
            end
        end
        chk("fast_cycles", cycles, 16);
        chk("fast_pass", pass1, 1);
        chk("fast_fc", fc1, 0);
        chk("fast_ffvalid", ffok1, 0);
`ifdef TT_CAPTURE_EN
        chk("fast_captured", cap1, 16'hA5C3);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
